rv32_main_ctrl: RTL and testbench
=================================

# rv32_main_ctrl

Multi-cycle main control FSM for the RV32I core. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB. Each cycle it drives the ALU operand selects and the 2-bit ALUop consumed by the ALU control decoder (00 = R/I funct-driven, 01 = branch SUB, 10 = ADD for address/PC math). It also handles the instruction/data memory request handshake and the register-file and PC write enables.

## Interface
Parameters:
- RESET_STATE_IDLE_CYCLES, 0, extra cycles held in FETCH with mem_req low after reset release (0 = request immediately)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0], stable except on the cycle after ir_write
- mem_ready  in  1  memory accepts/completes the current request this cycle
- branch_taken  in  1  ALU compare result, valid combinationally during EXEC of a branch
- alu_op  out  2  ALUop to the ALU control decoder
- alu_src_a  out  2  00 RS1, 01 PC, 10 OLDPC
- alu_src_b  out  2  00 RS2, 01 IMM, 10 constant 4
- mem_req  out  1  memory request
- mem_we  out  1  store strobe, valid with mem_req
- mem_addr_sel  out  1  0 PC, 1 ALUOUT register
- ir_write  out  1  load IR and OLDPC from fetch data / PC
- pc_write  out  1  update PC
- pc_sel  out  1  0 ALU result, 1 TARGET register
- target_write  out  1  latch ALU result into TARGET
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 ALUOUT, 01 MEM data, 10 LINK (current PC), 11 IMM
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky illegal-opcode flag
- state  out  3  current state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 are unused and recover to FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, alu_src_a=PC, alu_src_b=4, alu_op=10.
  - On mem_ready: ir_write=1, pc_write=1 (pc_sel=0), then go to DECODE.
  - Otherwise hold FETCH with all outputs unchanged.
- DECODE: alu_src_a=OLDPC, alu_src_b=IMM, alu_op=10, target_write=1. Classify the opcode into an internal class register. Go to EXEC.
- Opcode classes: 0x33 R, 0x13 I, 0x03 LD, 0x23 ST, 0x63 B, 0x6F JAL, 0x67 JALR, 0x37 LUI, 0x17 AUIPC. Anything else is ILL.
- EXEC, by class:
  - R: src_a RS1, src_b RS2, op 00, then WB.
  - I: src_a RS1, src_b IMM, op 00, then WB.
  - LD/ST: src_a RS1, src_b IMM, op 10, then MEM.
  - B: src_a RS1, src_b RS2, op 01. pc_write=branch_taken with pc_sel=1. retire=1, then FETCH.
  - JAL: pc_write=1, pc_sel=1, reg_write=1, wb_sel=LINK, retire=1, then FETCH.
  - JALR: src_a RS1, src_b IMM, op 10, pc_write=1, pc_sel=0, reg_write=1, wb_sel=LINK, retire=1, then FETCH.
  - LUI: reg_write=1, wb_sel=IMM, retire=1, then FETCH.
  - AUIPC: src_a OLDPC, src_b IMM, op 10, then WB.
  - ILL: see Configuration.
- LINK is the PC register value before this cycle's pc_write, which equals OLDPC+4.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(class==ST). Hold until mem_ready.
  - LD then goes to WB.
  - ST asserts retire and goes to FETCH.
- WB: reg_write=1, wb_sel=MEM for LD and ALUOUT otherwise. retire=1, then FETCH.
- Outputs not listed for a state are 0.

## Timing
- Reset: state=FETCH, class=R, illegal=0. Every output is forced to 0 while rst is high, including mem_req, so an in-flight memory transaction is abandoned.
- After rst falls, mem_req rises after RESET_STATE_IDLE_CYCLES cycles.
- Handshake:
  - mem_req stays high, with address select and we stable, until the rising edge at which mem_ready=1.
  - mem_req drops in the following cycle unless the next state requests again.
  - mem_ready is ignored while mem_req=0.
- Latency with zero wait states:
  - B, JAL, JALR, LUI: 3 cycles.
  - R, I, ST, AUIPC: 4 cycles.
  - LD: 5 cycles.
  - Each memory wait cycle adds 1.
- retire is exactly one cycle per completed instruction and is never asserted in FETCH or DECODE.
- branch_taken is sampled only in EXEC with class B. No input is registered.

## Configuration
- RV32_CTRL_ILLEGAL_EN defined:
  - ILL in EXEC goes to TRAP and sets illegal=1.
  - TRAP is absorbing: all outputs 0 and no retire until reset.
- RV32_CTRL_ILLEGAL_EN undefined:
  - ILL executes as a NOP: retire=1, then FETCH.
  - illegal is tied to 0 and TRAP is unreachable.

## Test plan
- ADD (0x33), mem_ready always 1 → states 0,1,2,4. alu_op=00 in EXEC, reg_write and retire pulse in cycle 4.
- LW (0x03), mem_ready low for 2 cycles in MEM → state 3 held 3 cycles with mem_req=1, mem_addr_sel=1, mem_we=0. Then WB with wb_sel=01, total 7 cycles.
- BEQ (0x63), branch_taken=1 then =0 on a second instance → alu_op=01 in EXEC. pc_write=1, pc_sel=1 only when taken. Each instance takes 3 cycles.
- JALR (0x67) → EXEC asserts pc_write, pc_sel=0, reg_write, wb_sel=10, retire, and the next state is FETCH.
- Opcode 0x7F with macro defined → state 5, illegal=1 stays high, mem_req stays 0. Without the macro → retire in EXEC, then FETCH.
- rst asserted during MEM of a store with mem_ready=0 → mem_req and mem_we drop asynchronously. After release, state=0 and illegal=0.

Source files
------------

// File: rtl/rv32_main_ctrl.sv
// Multi-cycle main control FSM for the RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshake and datapath enables. Define RV32_CTRL_ILLEGAL_EN to trap on illegal opcodes.
module rv32_main_ctrl #(
  parameter int unsigned RESET_STATE_IDLE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       target_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsR, ClsI, ClsLd, ClsSt, ClsB, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsIll
  } cls_e;

  localparam int unsigned CntW =
      (RESET_STATE_IDLE_CYCLES > 0) ? $clog2(RESET_STATE_IDLE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(RESET_STATE_IDLE_CYCLES);

  state_e          state_q;
  cls_e            cls_q;
  logic [CntW-1:0] idle_q;
  logic            idle;

  assign idle = (idle_q != '0);

  function automatic cls_e classify(input logic [6:0] op);
    case (op)
      7'h33:   return ClsR;
      7'h13:   return ClsI;
      7'h03:   return ClsLd;
      7'h23:   return ClsSt;
      7'h63:   return ClsB;
      7'h6F:   return ClsJal;
      7'h67:   return ClsJalr;
      7'h37:   return ClsLui;
      7'h17:   return ClsAuipc;
      default: return ClsIll;
    endcase
  endfunction

`ifdef RV32_CTRL_ILLEGAL_EN
  logic illegal_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      idle_q    <= CntInit;
`ifdef RV32_CTRL_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFetch: begin
          // Post-reset quiet period: mem_ready is ignored until the counter drains.
          if (idle) idle_q <= idle_q - 1'b1;
          else if (mem_ready) state_q <= StDecode;
        end
        StDecode: begin
          cls_q   <= classify(opcode);
          state_q <= StExec;
        end
        StExec: begin
          case (cls_q)
            ClsR, ClsI, ClsAuipc: state_q <= StWb;
            ClsLd, ClsSt:         state_q <= StMem;
            ClsIll: begin
`ifdef RV32_CTRL_ILLEGAL_EN
              state_q   <= StTrap;
              illegal_q <= 1'b1;
`else
              state_q   <= StFetch;
`endif
            end
            default:              state_q <= StFetch;
          endcase
        end
        StMem: begin
          if (mem_ready) state_q <= (cls_q == ClsLd) ? StWb : StFetch;
        end
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StTrap;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Outputs are decoded from the registered state and gated by rst so that an
  // in-flight request is dropped the moment reset rises.
  always_comb begin
    alu_op       = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    target_write = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    retire       = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          if (!idle) begin
            mem_req   = 1'b1;
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
          end
        end
        StDecode: begin
          alu_src_a    = 2'b10;
          alu_src_b    = 2'b01;
          alu_op       = 2'b10;
          target_write = 1'b1;
        end
        StExec: begin
          case (cls_q)
            ClsR: ;
            ClsI:  alu_src_b = 2'b01;
            ClsLd, ClsSt: begin
              alu_src_b = 2'b01;
              alu_op    = 2'b10;
            end
            ClsB: begin
              alu_op   = 2'b01;
              pc_write = branch_taken;
              pc_sel   = branch_taken;
              retire   = 1'b1;
            end
            ClsJal: begin
              pc_write  = 1'b1;
              pc_sel    = 1'b1;
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              retire    = 1'b1;
            end
            ClsJalr: begin
              alu_src_b = 2'b01;
              alu_op    = 2'b10;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              retire    = 1'b1;
            end
            ClsLui: begin
              reg_write = 1'b1;
              wb_sel    = 2'b11;
              retire    = 1'b1;
            end
            ClsAuipc: begin
              alu_src_a = 2'b10;
              alu_src_b = 2'b01;
              alu_op    = 2'b10;
            end
            default: begin
`ifndef RV32_CTRL_ILLEGAL_EN
              retire = 1'b1;
`endif
            end
          endcase
        end
        StMem: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls_q == ClsSt);
          retire       = (cls_q == ClsSt) && mem_ready;
        end
        StWb: begin
          reg_write = 1'b1;
          wb_sel    = (cls_q == ClsLd) ? 2'b01 : 2'b00;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RV32_CTRL_ILLEGAL_EN
  assign illegal = illegal_q && !rst;
`else
  assign illegal = 1'b0;
`endif

  assign state = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_rv32_main_ctrl.sv
// Directed self-checking bench for rv32_main_ctrl; every output is packed into one vector
// and compared cycle by cycle against hand-computed values.
module tb_rv32_main_ctrl;

  localparam int unsigned Idle = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_sel;
  logic       target_write, reg_write, retire, illegal;
  logic [2:0] state;
  logic [20:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_main_ctrl #(.RESET_STATE_IDLE_CYCLES(Idle)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .target_write (target_write),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .illegal      (illegal),
    .state        (state)
  );

  assign outs = {alu_op, alu_src_a, alu_src_b, mem_req, mem_we, mem_addr_sel, ir_write,
                 pc_write, pc_sel, target_write, reg_write, wb_sel, retire, illegal, state};

  function automatic logic [20:0] pk(
      input logic [1:0] aop, input logic [1:0] sa, input logic [1:0] sb,
      input logic mreq, input logic mwe, input logic mas, input logic irw,
      input logic pcw, input logic pcs, input logic tw, input logic rw,
      input logic [1:0] wbs, input logic ret, input logic ill, input logic [2:0] st);
    return {aop, sa, sb, mreq, mwe, mas, irw, pcw, pcs, tw, rw, wbs, ret, ill, st};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, let outputs settle, compare, advance past the edge.
  task automatic cyc(input string tag, input logic [6:0] op, input logic rdy, input logic bt,
                     input logic [20:0] exp);
    opcode       = op;
    mem_ready    = rdy;
    branch_taken = bt;
    #1;
    check(tag, {11'd0, outs}, {11'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [20:0] v_idle, v_fetch_rdy, v_fetch_wait, v_dec, v_wb_alu;

  initial begin
    v_idle       = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_fetch_rdy  = pk(2, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v_fetch_wait = pk(2, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_dec        = pk(2, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    v_wb_alu     = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4);

    rst = 1'b1; opcode = 7'h00; mem_ready = 1'b1; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {11'd0, outs}, 32'd0);
    rst = 1'b0;

    // Quiet period after reset: mem_ready is high but must be ignored.
    cyc("idle0", 7'h33, 1, 0, v_idle);
    cyc("idle1", 7'h33, 1, 0, v_idle);

    // ADD
    cyc("add_f", 7'h33, 1, 1, v_fetch_rdy);
    cyc("add_d", 7'h33, 1, 1, v_dec);
    cyc("add_e", 7'h33, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("add_w", 7'h33, 1, 1, v_wb_alu);

    // ADDI with one fetch wait state
    cyc("addi_fw", 7'h13, 0, 0, v_fetch_wait);
    cyc("addi_f", 7'h13, 1, 0, v_fetch_rdy);
    cyc("addi_d", 7'h13, 0, 0, v_dec);
    cyc("addi_e", 7'h13, 0, 0, pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("addi_w", 7'h13, 0, 0, v_wb_alu);

    // LW with two memory wait states
    cyc("lw_f", 7'h03, 1, 0, v_fetch_rdy);
    cyc("lw_d", 7'h03, 1, 0, v_dec);
    cyc("lw_e", 7'h03, 1, 0, pk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("lw_m0", 7'h03, 0, 0, pk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    cyc("lw_m1", 7'h03, 0, 0, pk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    cyc("lw_m2", 7'h03, 1, 0, pk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    cyc("lw_w", 7'h03, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4));

    // BEQ taken, then not taken
    cyc("beq1_f", 7'h63, 1, 1, v_fetch_rdy);
    cyc("beq1_d", 7'h63, 1, 1, v_dec);
    cyc("beq1_e", 7'h63, 1, 1, pk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 2));
    cyc("beq2_f", 7'h63, 1, 0, v_fetch_rdy);
    cyc("beq2_d", 7'h63, 1, 0, v_dec);
    cyc("beq2_e", 7'h63, 1, 0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));

    // JALR, JAL, LUI, AUIPC
    cyc("jalr_f", 7'h67, 1, 1, v_fetch_rdy);
    cyc("jalr_d", 7'h67, 1, 1, v_dec);
    cyc("jalr_e", 7'h67, 1, 1, pk(2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 2, 1, 0, 2));
    cyc("jal_f", 7'h6F, 1, 0, v_fetch_rdy);
    cyc("jal_d", 7'h6F, 1, 0, v_dec);
    cyc("jal_e", 7'h6F, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 1, 0, 2));
    cyc("lui_f", 7'h37, 1, 0, v_fetch_rdy);
    cyc("lui_d", 7'h37, 1, 0, v_dec);
    cyc("lui_e", 7'h37, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 2));
    cyc("auipc_f", 7'h17, 1, 0, v_fetch_rdy);
    cyc("auipc_d", 7'h17, 1, 0, v_dec);
    cyc("auipc_e", 7'h17, 1, 0, pk(2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("auipc_w", 7'h17, 1, 0, v_wb_alu);

    // SW completing with zero wait states
    cyc("sw_f", 7'h23, 1, 0, v_fetch_rdy);
    cyc("sw_d", 7'h23, 1, 0, v_dec);
    cyc("sw_e", 7'h23, 1, 0, pk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("sw_m", 7'h23, 1, 0, pk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3));

    // SW stalled in MEM, then reset mid-cycle
    cyc("sw2_f", 7'h23, 1, 0, v_fetch_rdy);
    cyc("sw2_d", 7'h23, 1, 0, v_dec);
    cyc("sw2_e", 7'h23, 1, 0, pk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("sw2_m", 7'h23, 0, 0, pk(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    mem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {11'd0, outs}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst_idle0", 7'h23, 1, 0, v_idle);
    cyc("post_rst_idle1", 7'h23, 1, 0, v_idle);

    // Illegal opcode
    cyc("ill_f", 7'h7F, 1, 0, v_fetch_rdy);
    cyc("ill_d", 7'h7F, 1, 0, v_dec);
`ifdef RV32_CTRL_ILLEGAL_EN
    cyc("ill_e", 7'h7F, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    cyc("trap0", 7'h7F, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
    cyc("trap1", 7'h33, 1, 1, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
`else
    cyc("ill_e", 7'h7F, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    cyc("ill_next", 7'h33, 1, 0, v_fetch_rdy);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("final_state", {29'd0, state}, 32'd0);
    check("final_illegal", {31'd0, illegal}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
